// File: rtl/inst_mem_loader.sv
// Byte-serial instruction memory loader: assembles MSB-first bytes into words,
// stops on an all-ones terminator or overflow, then serves registered fetches.
module inst_mem_loader #(
  parameter int DATA_W = 8,
  parameter int INST_W = 16,
  parameter int DEPTH  = 256,
  localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_restart,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_ready,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [INST_W-1:0] o_inst,
  output logic              o_load_done,
  output logic              o_overflow,
  output logic [ADDR_W:0]   o_count,
  output logic [1:0]        o_state
);

  localparam int BPI = INST_W / DATA_W;
  localparam int BCW = (BPI > 1) ? $clog2(BPI) : 1;
  localparam logic [BCW-1:0]  LAST_BYTE = BCW'(BPI - 1);
  localparam logic [ADDR_W:0] DEPTH_C   = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [INST_W-1:0] r_mem [DEPTH];
  logic [INST_W-1:0] r_shift;
  logic [BCW-1:0]    r_bcnt;
  logic [ADDR_W:0]   r_count;
  logic              r_overflow;
  logic [INST_W-1:0] r_inst;

  logic              w_accept;
  logic              w_word_done;
  logic [INST_W-1:0] w_word;
  logic              w_room;
  logic              w_term;
  logic              w_store;
  logic              w_ovf;

  // Handshake: a byte transfers on a rising edge where i_valid && o_ready;
  // restart wins over a coincident transfer, which is dropped.
  assign w_accept    = i_valid && (r_state == S_LOAD) && !i_restart;
  assign w_word_done = w_accept && (r_bcnt == LAST_BYTE);
  assign w_word      = (r_shift << DATA_W) | INST_W'(i_data);
  assign w_room      = (r_count < DEPTH_C);
  assign w_term      = (w_word == {INST_W{1'b1}});
  assign w_store     = w_word_done && w_room;
  assign w_ovf       = w_word_done && !w_room;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (i_restart) begin
      w_next = S_LOAD;
    end else begin
      case (r_state)
        S_IDLE:  w_next = S_LOAD;
        S_LOAD:  if (w_word_done && (w_term || !w_room)) w_next = S_DONE;
        S_DONE:  w_next = S_DONE;
        default: w_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shift    <= '0;
      r_bcnt     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_inst     <= '0;
    end else if (i_restart) begin
      r_shift    <= '0;
      r_bcnt     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_inst     <= '0;
    end else begin
      if (w_accept) begin
        if (r_bcnt == LAST_BYTE) begin
          r_bcnt  <= '0;
          r_shift <= '0;
        end else begin
          r_bcnt  <= r_bcnt + 1'b1;
          r_shift <= w_word;
        end
      end
      if (w_store) r_count <= r_count + 1'b1;
      if (w_ovf)   r_overflow <= 1'b1;
      // Slots at or beyond the count may hold stale data from an earlier load.
      if ((r_state == S_DONE) && ({1'b0, i_rd_addr} < r_count))
        r_inst <= r_mem[i_rd_addr];
      else
        r_inst <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_store) r_mem[r_count[ADDR_W-1:0]] <= w_word;
  end

  assign o_ready     = (r_state == S_LOAD);
  assign o_load_done = (r_state == S_DONE);
  assign o_overflow  = r_overflow;
  assign o_count     = r_count;
  assign o_inst      = r_inst;
  assign o_state     = r_state;

endmodule

// File: tb/tb_inst_mem_loader.sv
// Bench for inst_mem_loader: three instances (defaults, DEPTH=4, INST_W=24)
// driven by random byte streams and checked against a byte-stream model.
module tb_inst_mem_loader;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       valid   [3];
  logic [7:0] data    [3];
  logic       restart [3];
  logic [7:0] rd_addr [3];

  wire        ready [3];
  wire        done  [3];
  wire        ovf   [3];
  wire [1:0]  st    [3];
  wire [15:0] inst0;
  wire [15:0] inst1;
  wire [23:0] inst2;
  wire [8:0]  cnt0;
  wire [2:0]  cnt1;
  wire [4:0]  cnt2;

  inst_mem_loader #(.DATA_W(8), .INST_W(16), .DEPTH(256)) u_dut0 (
    .clk(clk), .rst(rst), .i_restart(restart[0]), .i_valid(valid[0]),
    .i_data(data[0]), .o_ready(ready[0]), .i_rd_addr(rd_addr[0]),
    .o_inst(inst0), .o_load_done(done[0]), .o_overflow(ovf[0]),
    .o_count(cnt0), .o_state(st[0])
  );

  inst_mem_loader #(.DATA_W(8), .INST_W(16), .DEPTH(4)) u_dut1 (
    .clk(clk), .rst(rst), .i_restart(restart[1]), .i_valid(valid[1]),
    .i_data(data[1]), .o_ready(ready[1]), .i_rd_addr(rd_addr[1][1:0]),
    .o_inst(inst1), .o_load_done(done[1]), .o_overflow(ovf[1]),
    .o_count(cnt1), .o_state(st[1])
  );

  inst_mem_loader #(.DATA_W(8), .INST_W(24), .DEPTH(16)) u_dut2 (
    .clk(clk), .rst(rst), .i_restart(restart[2]), .i_valid(valid[2]),
    .i_data(data[2]), .o_ready(ready[2]), .i_rd_addr(rd_addr[2][3:0]),
    .o_inst(inst2), .o_load_done(done[2]), .o_overflow(ovf[2]),
    .o_count(cnt2), .o_state(st[2])
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: the accepted byte stream folded into words.
  int          bpi_t   [3] = '{2, 2, 3};
  int          depth_t [3] = '{256, 4, 16};
  int          m_cnt   [3];
  int          m_bytes [3];
  bit          m_ovf   [3];
  bit          m_done  [3];
  logic [23:0] m_word  [3];
  logic [23:0] m_mem   [3][256];
  logic [23:0] exp_v;

  function automatic logic [23:0] f_inst(int d);
    case (d)
      0:       return {8'h00, inst0};
      1:       return {8'h00, inst1};
      default: return inst2;
    endcase
  endfunction

  function automatic int f_cnt(int d);
    case (d)
      0:       return int'(cnt0);
      1:       return int'(cnt1);
      default: return int'(cnt2);
    endcase
  endfunction

  function automatic logic [23:0] f_ones(int d);
    return 24'((1 << (8 * bpi_t[d])) - 1);
  endfunction

  task automatic model_clear(int d);
    m_cnt[d] = 0; m_bytes[d] = 0; m_ovf[d] = 0; m_done[d] = 0; m_word[d] = '0;
  endtask

  task automatic model_accept(int d, logic [7:0] b);
    if (m_done[d]) return;
    m_word[d] = ((m_word[d] << 8) | 24'(b)) & f_ones(d);
    m_bytes[d]++;
    if (m_bytes[d] == bpi_t[d]) begin
      m_bytes[d] = 0;
      if (m_cnt[d] < depth_t[d]) begin
        m_mem[d][m_cnt[d]] = m_word[d];
        m_cnt[d]++;
        if (m_word[d] == f_ones(d)) m_done[d] = 1;
      end else begin
        m_ovf[d] = 1;
        m_done[d] = 1;
      end
      m_word[d] = '0;
    end
  endtask

  // Drivers: called at a falling edge, return at a falling edge.
  task automatic send_byte(int d, logic [7:0] b, int gap);
    valid[d] = 1'b1;
    data[d]  = b;
    @(negedge clk);
    model_accept(d, b);
    if (gap > 0) begin
      valid[d] = 1'b0;
      data[d]  = 8'($urandom);
      repeat (gap) @(negedge clk);
    end
  endtask

  task automatic send_word(int d, logic [23:0] w, int maxgap);
    for (int k = 0; k < bpi_t[d]; k++)
      send_byte(d, 8'(w >> (8 * (bpi_t[d] - 1 - k))), int'($urandom_range(0, maxgap)));
    valid[d] = 1'b0;
  endtask

  task automatic do_restart(int d);
    restart[d] = 1'b1;
    @(negedge clk);
    restart[d] = 1'b0;
    model_clear(d);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    valid[0] = 1'b1;
    data[0]  = 8'hFF;
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      n_checks++; if (ready[d] !== 1'b0) begin n_errors++; $display("FAIL reset_ready[%0d]: got %b want 0", d, ready[d]); end
      n_checks++; if (done[d] !== 1'b0) begin n_errors++; $display("FAIL reset_done[%0d]: got %b want 0", d, done[d]); end
      n_checks++; if (ovf[d] !== 1'b0) begin n_errors++; $display("FAIL reset_ovf[%0d]: got %b want 0", d, ovf[d]); end
      n_checks++; if (f_cnt(d) !== 0) begin n_errors++; $display("FAIL reset_count[%0d]: got %0d want 0", d, f_cnt(d)); end
      n_checks++; if (f_inst(d) !== 24'h0) begin n_errors++; $display("FAIL reset_inst[%0d]: got %h want 0", d, f_inst(d)); end
      model_clear(d);
    end
    valid[0] = 1'b0;
    rst = 1'b0;
    #1;
    n_checks++; if (ready[0] !== 1'b0) begin n_errors++; $display("FAIL reset_idle_ready: got %b want 0", ready[0]); end
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      n_checks++; if (ready[d] !== 1'b1) begin n_errors++; $display("FAIL reset_load_ready[%0d]: got %b want 1", d, ready[d]); end
    end
  endtask

  task automatic test_basic_load();
    logic [7:0] bytes [8] = '{8'hAB, 8'hCD, 8'h01, 8'h01, 8'h24, 8'h24, 8'hFF, 8'hFF};
    for (int i = 0; i < 7; i++) send_byte(0, bytes[i], 0);
    n_checks++; if (done[0] !== 1'b0) begin n_errors++; $display("FAIL basic_done_early: got %b want 0", done[0]); end
    send_byte(0, bytes[7], 0);
    valid[0] = 1'b0;
    n_checks++; if (done[0] !== 1'b1) begin n_errors++; $display("FAIL basic_done: got %b want 1", done[0]); end
    n_checks++; if (ready[0] !== 1'b0) begin n_errors++; $display("FAIL basic_ready: got %b want 0", ready[0]); end
    n_checks++; if (f_cnt(0) !== m_cnt[0]) begin n_errors++; $display("FAIL basic_count: got %0d want %0d", f_cnt(0), m_cnt[0]); end
    for (int a = 0; a < 6; a++) begin
      rd_addr[0] = 8'(a);
      @(negedge clk);
      exp_v = (m_done[0] && a < m_cnt[0]) ? m_mem[0][a] : 24'h0;
      n_checks++; if (f_inst(0) !== exp_v) begin n_errors++; $display("FAIL basic_fetch[%0d]: got %h want %h", a, f_inst(0), exp_v); end
    end
  endtask

  task automatic test_alignment();
    logic [7:0] bytes [6] = '{8'h12, 8'hFF, 8'hFF, 8'h34, 8'hFF, 8'hFF};
    do_restart(0);
    for (int i = 0; i < 6; i++) begin
      send_byte(0, bytes[i], 0);
      if (i == 3 || i == 4) begin
        n_checks++; if (done[0] !== 1'b0) begin n_errors++; $display("FAIL align_done_early[%0d]: got %b want 0", i, done[0]); end
      end
    end
    valid[0] = 1'b0;
    n_checks++; if (done[0] !== 1'b1) begin n_errors++; $display("FAIL align_done: got %b want 1", done[0]); end
    n_checks++; if (f_cnt(0) !== m_cnt[0]) begin n_errors++; $display("FAIL align_count: got %0d want %0d", f_cnt(0), m_cnt[0]); end
    for (int a = 0; a < 4; a++) begin
      rd_addr[0] = 8'(a);
      @(negedge clk);
      exp_v = (m_done[0] && a < m_cnt[0]) ? m_mem[0][a] : 24'h0;
      n_checks++; if (f_inst(0) !== exp_v) begin n_errors++; $display("FAIL align_fetch[%0d]: got %h want %h", a, f_inst(0), exp_v); end
    end
  endtask

  task automatic test_overflow();
    logic [23:0] w;
    do_restart(1);
    for (int i = 0; i < 5; i++) begin
      w = 24'($urandom_range(0, 16'hFFFE));
      send_word(1, w, 1);
      if (i == 3) begin
        n_checks++; if (done[1] !== 1'b0 || ovf[1] !== 1'b0) begin n_errors++; $display("FAIL ovf_full_state: got done=%b ovf=%b want 0 0", done[1], ovf[1]); end
      end
    end
    n_checks++; if (ovf[1] !== m_ovf[1]) begin n_errors++; $display("FAIL ovf_flag: got %b want %b", ovf[1], m_ovf[1]); end
    n_checks++; if (done[1] !== m_done[1]) begin n_errors++; $display("FAIL ovf_done: got %b want %b", done[1], m_done[1]); end
    n_checks++; if (f_cnt(1) !== m_cnt[1]) begin n_errors++; $display("FAIL ovf_count: got %0d want %0d", f_cnt(1), m_cnt[1]); end
    for (int a = 0; a < 4; a++) begin
      rd_addr[1] = 8'(a);
      @(negedge clk);
      exp_v = (m_done[1] && a < m_cnt[1]) ? m_mem[1][a] : 24'h0;
      n_checks++; if (f_inst(1) !== exp_v) begin n_errors++; $display("FAIL ovf_fetch[%0d]: got %h want %h", a, f_inst(1), exp_v); end
    end
    // Terminator landing in the last slot is stored without overflow.
    do_restart(1);
    n_checks++; if (ovf[1] !== 1'b0) begin n_errors++; $display("FAIL ovf_restart_clear: got %b want 0", ovf[1]); end
    for (int i = 0; i < 3; i++) send_word(1, 24'($urandom_range(0, 16'hFFFE)), 0);
    send_word(1, 24'hFFFF, 0);
    n_checks++; if (ovf[1] !== m_ovf[1]) begin n_errors++; $display("FAIL edge_ovf: got %b want %b", ovf[1], m_ovf[1]); end
    n_checks++; if (done[1] !== m_done[1]) begin n_errors++; $display("FAIL edge_done: got %b want %b", done[1], m_done[1]); end
    n_checks++; if (f_cnt(1) !== m_cnt[1]) begin n_errors++; $display("FAIL edge_count: got %0d want %0d", f_cnt(1), m_cnt[1]); end
    rd_addr[1] = 8'd3;
    @(negedge clk);
    exp_v = m_mem[1][3];
    n_checks++; if (f_inst(1) !== exp_v) begin n_errors++; $display("FAIL edge_fetch3: got %h want %h", f_inst(1), exp_v); end
  endtask

  task automatic test_gaps();
    do_restart(0);
    send_word(0, 24'h0A0B, 4);
    send_word(0, 24'hFFFF, 4);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (ready[0] !== 1'b0) begin n_errors++; $display("FAIL gaps_ready_done[%0d]: got %b want 0", i, ready[0]); end
      send_byte(0, 8'($urandom), 0);
    end
    valid[0] = 1'b0;
    n_checks++; if (f_cnt(0) !== m_cnt[0]) begin n_errors++; $display("FAIL gaps_count: got %0d want %0d", f_cnt(0), m_cnt[0]); end
    for (int a = 0; a < 3; a++) begin
      rd_addr[0] = 8'(a);
      @(negedge clk);
      exp_v = (m_done[0] && a < m_cnt[0]) ? m_mem[0][a] : 24'h0;
      n_checks++; if (f_inst(0) !== exp_v) begin n_errors++; $display("FAIL gaps_fetch[%0d]: got %h want %h", a, f_inst(0), exp_v); end
    end
  endtask

  task automatic test_restart();
    n_checks++; if (done[0] !== 1'b1) begin n_errors++; $display("FAIL restart_pre_done: got %b want 1", done[0]); end
    rd_addr[0] = 8'd0;
    valid[0] = 1'b1;
    data[0]  = 8'h77;
    do_restart(0);
    valid[0] = 1'b0;
    n_checks++; if (f_cnt(0) !== 0) begin n_errors++; $display("FAIL restart_count: got %0d want 0", f_cnt(0)); end
    n_checks++; if (ready[0] !== 1'b1) begin n_errors++; $display("FAIL restart_ready: got %b want 1", ready[0]); end
    n_checks++; if (f_inst(0) !== 24'h0) begin n_errors++; $display("FAIL restart_inst_load: got %h want 0", f_inst(0)); end
    send_word(0, 24'h5555, 0);
    send_word(0, 24'hFFFF, 0);
    n_checks++; if (f_cnt(0) !== m_cnt[0]) begin n_errors++; $display("FAIL restart_new_count: got %0d want %0d", f_cnt(0), m_cnt[0]); end
    n_checks++; if (ovf[0] !== 1'b0) begin n_errors++; $display("FAIL restart_ovf: got %b want 0", ovf[0]); end
    @(negedge clk);
    n_checks++; if (f_inst(0) !== m_mem[0][0]) begin n_errors++; $display("FAIL restart_fetch0: got %h want %h", f_inst(0), m_mem[0][0]); end
  endtask

  task automatic test_reset_midload();
    do_restart(0);
    send_byte(0, 8'hA5, 0);
    valid[0] = 1'b0;
    rst = 1'b1;
    #1;
    n_checks++; if (f_cnt(0) !== 0) begin n_errors++; $display("FAIL midrst_count: got %0d want 0", f_cnt(0)); end
    n_checks++; if (ready[0] !== 1'b0) begin n_errors++; $display("FAIL midrst_ready: got %b want 0", ready[0]); end
    @(negedge clk);
    rst = 1'b0;
    for (int d = 0; d < 3; d++) model_clear(d);
    #1;
    n_checks++; if (ready[0] !== 1'b0) begin n_errors++; $display("FAIL midrst_idle: got %b want 0", ready[0]); end
    @(negedge clk);
    n_checks++; if (ready[0] !== 1'b1) begin n_errors++; $display("FAIL midrst_load: got %b want 1", ready[0]); end
    send_word(0, 24'hAABB, 0);
    send_word(0, 24'hFFFF, 0);
    for (int a = 0; a < 3; a++) begin
      rd_addr[0] = 8'(a);
      @(negedge clk);
      exp_v = (m_done[0] && a < m_cnt[0]) ? m_mem[0][a] : 24'h0;
      n_checks++; if (f_inst(0) !== exp_v) begin n_errors++; $display("FAIL midrst_fetch[%0d]: got %h want %h", a, f_inst(0), exp_v); end
    end
  endtask

  task automatic test_inst24();
    do_restart(2);
    send_word(2, 24'h112233, 0);
    send_word(2, 24'hFFFFFF, 0);
    n_checks++; if (done[2] !== 1'b1) begin n_errors++; $display("FAIL i24_done: got %b want 1", done[2]); end
    n_checks++; if (f_cnt(2) !== m_cnt[2]) begin n_errors++; $display("FAIL i24_count: got %0d want %0d", f_cnt(2), m_cnt[2]); end
    for (int a = 0; a < 3; a++) begin
      rd_addr[2] = 8'(a);
      @(negedge clk);
      exp_v = (m_done[2] && a < m_cnt[2]) ? m_mem[2][a] : 24'h0;
      n_checks++; if (f_inst(2) !== exp_v) begin n_errors++; $display("FAIL i24_fetch[%0d]: got %h want %h", a, f_inst(2), exp_v); end
    end
  endtask

  task automatic test_random();
    int d;
    int n;
    int lim;
    for (int it = 0; it < 10; it++) begin
      d = (it % 2 == 0) ? 0 : 2;
      n = int'($urandom_range(1, 20));
      do_restart(d);
      for (int i = 0; i < n - 1; i++) begin
        if ($urandom_range(0, 15) == 0) send_word(d, f_ones(d), 2);
        else send_word(d, 24'($urandom) & f_ones(d), 2);
      end
      send_word(d, f_ones(d), 2);
      n_checks++; if (done[d] !== m_done[d]) begin n_errors++; $display("FAIL rand_done[%0d]: got %b want %b", it, done[d], m_done[d]); end
      n_checks++; if (ovf[d] !== m_ovf[d]) begin n_errors++; $display("FAIL rand_ovf[%0d]: got %b want %b", it, ovf[d], m_ovf[d]); end
      n_checks++; if (f_cnt(d) !== m_cnt[d]) begin n_errors++; $display("FAIL rand_count[%0d]: got %0d want %0d", it, f_cnt(d), m_cnt[d]); end
      lim = (d == 0) ? 22 : 16;
      for (int a = 0; a < lim; a++) begin
        rd_addr[d] = 8'(a);
        @(negedge clk);
        exp_v = (m_done[d] && a < m_cnt[d]) ? m_mem[d][a] : 24'h0;
        n_checks++; if (f_inst(d) !== exp_v) begin n_errors++; $display("FAIL rand_fetch[%0d][%0d]: got %h want %h", it, a, f_inst(d), exp_v); end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    for (int d = 0; d < 3; d++) begin
      valid[d] = 1'b0; data[d] = 8'h00; restart[d] = 1'b0; rd_addr[d] = 8'h00;
    end
    repeat (2) @(negedge clk);
    test_reset();
    test_basic_load();
    test_alignment();
    test_overflow();
    test_gaps();
    test_restart();
    test_reset_midload();
    test_inst24();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/inst_mem_loader.md
INST_MEM_LOADER -- requirements
Module: inst_mem_loader

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning width of the byte-serial load bus.
REQ-002 SHALL have parameter INST_W, default 16, meaning instruction width; it must be an integer multiple (BPI = INST_W/DATA_W, BPI >= 1) of DATA_W.
REQ-003 SHALL have parameter DEPTH, default 256, meaning instruction slots; ADDR_W = $clog2(DEPTH), minimum 1.
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port i_restart  input  1  synchronous request to re-enter loading.
REQ-007 SHALL have port i_valid  input  1  load byte valid.
REQ-008 SHALL have port i_data  input  DATA_W  load byte, most-significant byte of each instruction first.
REQ-009 SHALL have port o_ready  output  1  block accepts load bytes.
REQ-010 SHALL have port i_rd_addr  input  ADDR_W  instruction fetch address.
REQ-011 SHALL have port o_inst  output  INST_W  registered fetch data.
REQ-012 SHALL have port o_load_done  output  1  load finished, fetch enabled.
REQ-013 SHALL have port o_overflow  output  1  sticky: load exceeded DEPTH.
REQ-014 SHALL have port o_count  output  ADDR_W+1  instructions stored, including terminator.

Function
REQ-015 SHALL implement FSM states IDLE, LOAD, DONE; IDLE->LOAD unconditionally after one cycle; LOAD->DONE on terminator or overflow; DONE holds until i_restart.
REQ-016 SHALL drive o_ready = (state == LOAD) and o_load_done = (state == DONE), both decoded from registered state.
REQ-017 SHALL accept a byte only on a rising edge with i_valid && o_ready; i_valid while o_ready is low is ignored.
REQ-018 SHALL assemble BPI accepted bytes MSB-first into one word using a byte counter 0..BPI-1; i_valid gaps of any length do not disturb a partial word.
REQ-019 SHALL, on the edge accepting byte BPI-1, write the assembled word to mem[wr_ptr] and increment wr_ptr and o_count, when wr_ptr < DEPTH.
REQ-020 SHALL treat a completed word equal to all ones as terminator: it is stored like any word (acts as HALT), and the FSM moves to DONE on that same edge.
REQ-021 SHALL detect terminators only on instruction-aligned words; all-ones bytes straddling two words are ordinary data.
REQ-022 SHALL, when a word completes with wr_ptr == DEPTH, discard it, set o_overflow, and move to DONE; a terminator completing at wr_ptr == DEPTH - 1 is stored with no overflow.
REQ-023 SHALL, in DONE, register o_inst <= mem[i_rd_addr] when i_rd_addr < o_count, else all zeros; latency is one cycle.
REQ-024 SHALL hold o_inst at zero in IDLE and LOAD.
REQ-025 SHALL, on i_restart in any state, clear wr_ptr, byte counter, partial word, o_count and o_overflow and enter LOAD next cycle; it takes priority over a simultaneous byte accept, which is dropped.
REQ-026 SHALL leave memory contents unreset; stale entries are masked by REQ-023.

Reset
REQ-027 SHALL, while rst is high, force state IDLE, o_ready 0, o_load_done 0, o_overflow 0, o_count 0, o_inst 0, byte counter and wr_ptr 0.
REQ-028 SHALL, on rst asserted mid-load, abandon the partial word; the first cycle after release is IDLE, with o_ready high from the second.

Verification
REQ-029 SHALL verify basic load (defaults): bytes AB CD 01 01 24 24 FF FF, i_valid continuous -> o_count 4, o_load_done high the cycle after the last FF, fetches 0..3 give ABCD 0101 2424 FFFF one cycle later; addr 4 gives 0000.
REQ-030 SHALL verify alignment: bytes 12 FF FF 34 FF FF -> words 12FF, FF34, FFFF; DONE only after the third word, o_count 3.
REQ-031 SHALL verify overflow (DEPTH=4): five non-terminator words -> o_overflow 1, o_count 4, fifth word absent, addresses 0..3 hold the first four.
REQ-032 SHALL verify backpressure/gaps: i_valid toggled with idle cycles between bytes of 0A0B, FFFF -> same memory result as continuous stream; bytes offered during DONE are ignored.
REQ-033 SHALL verify restart and reset: i_restart in DONE then load 5555, FFFF -> o_count 2, o_overflow cleared, fetch 0 gives 5555; rst pulsed after one byte -> o_count 0, o_ready 0 then 1.
REQ-034 SHALL verify parameter variant INST_W=24, DATA_W=8: bytes 11 22 33 FF FF FF -> mem[0]=112233, mem[1]=FFFFFF, DONE.
